fir_feeder: RTL
===============

// Module: fir_feeder
// PURPOSE
// Upstream stage of the 8-tap FIR filter (myfir). Buffers incoming samples from a ready/valid source.
// Holds the eight coefficient registers, written through a small config port.
// Paces samples into the filter as single-cycle Vin/Din strobes, with a programmable minimum gap.
// Run/stop FSM: coefficients change only while the filter input is idle.
// PARAMETERS
// DW          13   sample/coefficient width, signed two's complement
// NTAPS       8    number of coefficient registers (H0..H7)
// FIFO_DEPTH  16   sample FIFO entries, power of two, >=2
// PORTS
// clk        in   1        system clock, rising edge
// RST_n      in   1        asynchronous active-low reset
// cfg_we     in   1        coefficient write strobe
// cfg_addr   in   3        coefficient index 0..7
// cfg_data   in   DW       coefficient value, signed
// cfg_err    out  1        sticky: a write was dropped because state!=IDLE; cleared by start
// start      in   1        pulse: IDLE->RUN
// stop       in   1        pulse: RUN->DRAIN
// gap        in   4        idle cycles forced between Vin pulses (0 = back-to-back)
// s_valid    in   1        source sample valid
// s_data     in   DW       source sample, signed
// s_ready    out  1        = !fifo_full
// Vin        out  1        one-cycle sample strobe to the filter
// Din        out  DW       sample to the filter, valid when Vin=1
// H0..H7     out  DW each  active coefficients
// busy       out  1        state!=IDLE
// level      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
// - Reset (RST_n=0, asynchronous): state=IDLE, FIFO empty, level=0, s_ready=1, Vin=0, Din=0.
//   Reset also clears H0..H7=0, cfg_err=0 and pace_cnt=0. A reset mid-run discards buffered samples.
// - Push: fires when s_valid&&s_ready, in any state. s_ready depends only on full.
//   A full FIFO refuses a push even when a pop occurs in the same cycle.
//   Simultaneous push and pop on a non-full, non-empty FIFO leaves level unchanged.
// - Coefficient write: in IDLE, cfg_we writes cfg_data to H[cfg_addr] at the next edge.
//   In RUN or DRAIN the write is dropped and cfg_err<=1.
// - FSM:
//   IDLE -start->  RUN (cfg_err<=0).
//   RUN  -stop->   DRAIN.
//   DRAIN -(FIFO empty && pace_cnt==0)-> IDLE.
//   start outside IDLE is ignored; stop outside RUN is ignored; start&&stop in IDLE -> RUN.
// - Issue rule: issue = (state in {RUN,DRAIN}) && !empty && pace_cnt==0.
//   On issue: pop the head; at the next edge Vin<=1, Din<=head, pace_cnt<=gap.
//   Otherwise Vin<=0, Din holds its value, and pace_cnt decrements while >0.
// - Latency: a sample pushed at edge t into an empty FIFO in RUN gives Vin=1 after edge t+1.
//   Din equals that sample in the same cycle. Samples leave in FIFO order, none lost or duplicated.
// - gap sampled at each issue; changes mid-run affect the next interval only.
// - Vin period = gap+1 cycles while FIFO non-empty. Vin is never asserted in IDLE.
// - Pointers wrap modulo FIFO_DEPTH. level is saturation-free and exact by construction.
// STRUCTURE
// - Package fir_pkg holds: DW, NTAPS; typedef logic signed [DW-1:0] sample_t, coef_t;
//   typedef enum logic [1:0] {IDLE, RUN, DRAIN} feed_state_t.
// - One sub-module, fir_sfifo: synchronous single-clock FIFO with registered pointers and count.
//   Outputs full, empty, level and head; no output register.
// - Top holds the FSM, pace counter, coefficient bank and the Vin/Din output registers.
// TESTING
// 1 Reset mid-run with 5 samples queued -> Vin=0, level=0, H0..H7=0, s_ready=1 immediately.
// 2 IDLE: write H3=-7, H7=4095 -> H3=13'h1FF9, H7=13'h0FFF.
//   Then start and write H0=5 in RUN -> H0 stays 0, cfg_err=1.
// 3 RUN, gap=0, push 1,2,3 on consecutive cycles -> Vin high 3 consecutive cycles.
//   Din=1,2,3, first Vin one cycle after the first push edge.
// 4 RUN, gap=3, 4 samples queued -> Vin pulses exactly 4 cycles apart, Din in order.
// 5 Stop held off (IDLE), push 16 -> s_ready=0, 17th sample refused, level=16.
//   Then start, gap=0 -> 16 Vin pulses; s_ready=1 after the first pop.
// 6 RUN with 3 queued, pulse stop -> DRAIN, 3 more Vin, then busy=0, IDLE; start+stop together -> RUN.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and sizes for the FIR front-end feeder.
package fir_pkg;

    localparam int DW    = 13;
    localparam int NTAPS = 8;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [DW-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } feed_state_t;

endpackage

// File: rtl/fir_sfifo.sv
// Single-clock sample FIFO: registered pointers and occupancy, combinational head.
module fir_sfifo
    import fir_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  sample_t       wdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output sample_t       head
);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fir_feeder.sv
// Feeds buffered samples into the 8-tap FIR as paced Vin/Din strobes and
// owns the coefficient bank, which is writable only while stopped.
module fir_feeder
    import fir_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  coef_t         cfg_data,
    output logic          cfg_err,
    input  logic          start,
    input  logic          stop,
    input  logic [3:0]    gap,
    input  logic          s_valid,
    input  sample_t       s_data,
    output logic          s_ready,
    output logic          Vin,
    output sample_t       Din,
    output coef_t         H0,
    output coef_t         H1,
    output coef_t         H2,
    output coef_t         H3,
    output coef_t         H4,
    output coef_t         H5,
    output coef_t         H6,
    output coef_t         H7,
    output logic          busy,
    output logic [LW-1:0] level
);

    feed_state_t   state;
    logic [3:0]    pace_cnt;
    coef_t         h [NTAPS];
    logic          full;
    logic          empty;
    sample_t       head;
    logic          issue;

    assign issue   = (state != IDLE) && !empty && (pace_cnt == '0);
    assign s_ready = !full;
    assign busy    = (state != IDLE);

    assign H0 = h[0];
    assign H1 = h[1];
    assign H2 = h[2];
    assign H3 = h[3];
    assign H4 = h[4];
    assign H5 = h[5];
    assign H6 = h[6];
    assign H7 = h[7];

    fir_sfifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (RST_n),
        .push  (s_valid),
        .pop   (issue),
        .wdata (s_data),
        .full  (full),
        .empty (empty),
        .level (level),
        .head  (head)
    );

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state    <= IDLE;
            cfg_err  <= 1'b0;
            pace_cnt <= '0;
            Vin      <= 1'b0;
            Din      <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                h[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                if (state == IDLE) begin
                    h[cfg_addr] <= cfg_data;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        cfg_err <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty && (pace_cnt == '0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                Vin      <= 1'b1;
                Din      <= head;
                pace_cnt <= gap;
            end else begin
                Vin <= 1'b0;
                if (pace_cnt != '0) begin
                    pace_cnt <= pace_cnt - 4'd1;
                end
            end
        end
    end

endmodule
